// File: rtl/clock_595_param.sv
// BCD real-time clock with 12/24h display and a 74HC595 digit scanner.
// Define ALARM_EN to build in the hh:mm alarm.
module clock_595_param #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int SCLK_DIV = 4,
  parameter int NDIG     = 6
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       hour12_in,
  input  logic       set_en_in,
  input  logic [7:0] set_hour_in,
  input  logic [7:0] set_min_in,
  input  logic [7:0] set_sec_in,
  output logic       set_err_out,
  input  logic [7:0] alarm_hour_in,
  input  logic [7:0] alarm_min_in,
  output logic       alarm_out,
  output logic       pm_out,
  output logic [3:0] sec_ge,
  output logic [3:0] sec_shi,
  output logic [3:0] min_ge,
  output logic [3:0] min_shi,
  output logic [3:0] hour_ge,
  output logic [3:0] hour_shi,
  output logic       rclk_out,
  output logic       sclk_out,
  output logic       sdio_out
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam int DW = $clog2(SCLK_DIV) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  logic [PW-1:0] pre;
  logic          tick;
  logic [3:0]    h_t, h_o, m_t, m_o, s_t, s_o;
  logic [3:0]    n_ht, n_ho, n_mt, n_mo, n_st, n_so;
  logic          set_ok, set_err_q;
  logic [4:0]    hbin, dh;

  assign tick = (pre == PRE_LAST);

  assign set_ok = set_hour_in[7:4] <= 4'd2
               && set_hour_in[3:0] <= 4'd9
               && !(set_hour_in[7:4] == 4'd2
                    && set_hour_in[3:0] > 4'd3)
               && set_min_in[7:4] <= 4'd5
               && set_min_in[3:0] <= 4'd9
               && set_sec_in[7:4] <= 4'd5
               && set_sec_in[3:0] <= 4'd9;

  // full carry chain resolves in the tick cycle
  always_comb begin
    n_so = s_o + 4'd1;
    n_st = s_t;
    n_mo = m_o;
    n_mt = m_t;
    n_ho = h_o;
    n_ht = h_t;
    if (s_o == 4'd9) begin
      n_so = 4'd0;
      n_st = s_t + 4'd1;
      if (s_t == 4'd5) begin
        n_st = 4'd0;
        n_mo = m_o + 4'd1;
        if (m_o == 4'd9) begin
          n_mo = 4'd0;
          n_mt = m_t + 4'd1;
          if (m_t == 4'd5) begin
            n_mt = 4'd0;
            n_ho = h_o + 4'd1;
            if (h_t == 4'd2 && h_o == 4'd3) begin
              n_ht = 4'd0;
              n_ho = 4'd0;
            end else if (h_o == 4'd9) begin
              n_ho = 4'd0;
              n_ht = h_t + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre       <= '0;
      {h_t, h_o, m_t, m_o, s_t, s_o} <= '0;
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= set_en_in && !set_ok;
      if (set_en_in && set_ok) begin
        pre <= '0;
        {h_t, h_o} <= set_hour_in;
        {m_t, m_o} <= set_min_in;
        {s_t, s_o} <= set_sec_in;
      end else if (tick) begin
        pre <= '0;
        {h_t, h_o, m_t, m_o, s_t, s_o} <=
          {n_ht, n_ho, n_mt, n_mo, n_st, n_so};
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  assign set_err_out = set_err_q;
  assign sec_ge  = s_o;
  assign sec_shi = s_t;
  assign min_ge  = m_o;
  assign min_shi = m_t;

  assign hbin   = 5'(h_t) * 5'd10 + 5'(h_o);
  assign pm_out = hbin >= 5'd12;

  always_comb begin
    dh = hbin;
    if (hbin == 5'd0) dh = 5'd12;
    else if (hbin > 5'd12) dh = hbin - 5'd12;
    hour_shi = h_t;
    hour_ge  = h_o;
    if (hour12_in) begin
      hour_shi = (dh >= 5'd10) ? 4'd1 : 4'd0;
      hour_ge  = (dh >= 5'd10) ? 4'(dh - 5'd10) : dh[3:0];
    end
  end

`ifdef ALARM_EN
  logic       alarm_q;
  logic [5:0] alarm_cnt;
  logic       alarm_hit;

  // post-increment time, so the match lands on the tick that reaches hh:mm:00
  assign alarm_hit = {n_ht, n_ho} == alarm_hour_in
                  && {n_mt, n_mo} == alarm_min_in
                  && {n_st, n_so} == 8'h00;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (set_en_in && set_ok) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (tick) begin
      if (alarm_hit) begin
        alarm_q   <= 1'b1;
        alarm_cnt <= '0;
      end else if (alarm_q) begin
        if (alarm_cnt == 6'd59) alarm_q <= 1'b0;
        alarm_cnt <= alarm_cnt + 6'd1;
      end
    end
  end

  assign alarm_out = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hour_in, alarm_min_in};
  assign alarm_out    = 1'b0;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  state_t      st, st_n;
  logic [DW-1:0] div, div_n;
  logic [3:0]  bitn, bit_n;
  logic        hi, hi_n;
  logic [15:0] word, word_n, frame_w;
  logic [2:0]  idx, idx_n;
  logic        sclk_q, sclk_n, rclk_q, rclk_n;
  logic        sdio_q, sdio_n;
  logic [3:0]  digs [0:7];

  assign digs[0] = sec_ge;
  assign digs[1] = sec_shi;
  assign digs[2] = min_ge;
  assign digs[3] = min_shi;
  assign digs[4] = hour_ge;
  assign digs[5] = hour_shi;
  assign digs[6] = 4'hF;
  assign digs[7] = 4'hF;

  assign frame_w = {seg7(digs[idx]), ~(8'd1 << idx)};

  always_comb begin
    st_n   = st;
    div_n  = div;
    bit_n  = bitn;
    hi_n   = hi;
    word_n = word;
    idx_n  = idx;
    sclk_n = sclk_q;
    rclk_n = rclk_q;
    sdio_n = sdio_q;
    unique case (st)
      S_IDLE: begin
        word_n = frame_w;
        sdio_n = frame_w[15];
        sclk_n = 1'b0;
        rclk_n = 1'b0;
        div_n  = '0;
        bit_n  = '0;
        hi_n   = 1'b0;
        st_n   = S_SHIFT;
      end
      S_SHIFT: begin
        div_n = div + DW'(1);
        if (div == DIV_LAST) begin
          div_n  = '0;
          hi_n   = !hi;
          sclk_n = !hi;
          if (hi) begin
            if (bitn == 4'd15) begin
              st_n   = S_LATCH;
              rclk_n = 1'b1;
              sdio_n = 1'b0;
            end else begin
              bit_n  = bitn + 4'd1;
              word_n = {word[14:0], 1'b0};
              sdio_n = word[14];
            end
          end
        end
      end
      S_LATCH: begin
        div_n = div + DW'(1);
        if (div == DIV_LAST) begin
          div_n  = '0;
          rclk_n = 1'b0;
          st_n   = S_IDLE;
          idx_n  = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st     <= S_IDLE;
      div    <= '0;
      bitn   <= '0;
      hi     <= 1'b0;
      word   <= '0;
      idx    <= '0;
      sclk_q <= 1'b0;
      rclk_q <= 1'b0;
      sdio_q <= 1'b0;
    end else begin
      st     <= st_n;
      div    <= div_n;
      bitn   <= bit_n;
      hi     <= hi_n;
      word   <= word_n;
      idx    <= idx_n;
      sclk_q <= sclk_n;
      rclk_q <= rclk_n;
      sdio_q <= sdio_n;
    end
  end

  assign sclk_out = sclk_q;
  assign rclk_out = rclk_q;
  assign sdio_out = sdio_q;

endmodule
